// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order WB stage and a long-latency unit.
// LLU results wait in a small FIFO. Entries overwritten by younger WB writes are squashed.
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int REGNO_W      = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pipe_valid,
    input  logic               pipe_wr,
    input  logic [REGNO_W-1:0] pipe_regno,
    input  logic [DATA_W-1:0]  pipe_val,
    output logic               pipe_stall,
    input  logic               llu_valid,
    input  logic [REGNO_W-1:0] llu_regno,
    input  logic [DATA_W-1:0]  llu_val,
    output logic               llu_ready,
    output logic               rf_we,
    output logic [REGNO_W-1:0] rf_wregno,
    output logic [DATA_W-1:0]  rf_wval,
    output logic [31:0]        stall_cycles
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIMIT);

    logic [REGNO_W-1:0] mem_regno_q [FIFO_DEPTH];
    logic [REGNO_W-1:0] mem_regno_d [FIFO_DEPTH];
    logic [DATA_W-1:0]  mem_val_q   [FIFO_DEPTH];
    logic [DATA_W-1:0]  mem_val_d   [FIFO_DEPTH];
    logic               mem_kill_q  [FIFO_DEPTH];
    logic               mem_kill_d  [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [AGE_W-1:0]   age_q, age_d;
    logic [31:0]        stall_cycles_q, stall_cycles_d;

    logic full, head_vld, head_kill, head_live, pipe_req;
    logic fifo_grant, pipe_grant, push, pop;

    always_comb begin
        full       = (count_q == DEPTH_C);
        head_vld   = (count_q != '0);
        head_kill  = mem_kill_q[rd_ptr_q];
        head_live  = head_vld && !head_kill;
        pipe_req   = !reset && pipe_valid && pipe_wr && (pipe_regno != '0);
        fifo_grant = !reset && head_live && (full || (age_q >= AGE_LIM) || !pipe_req);
        pipe_grant = pipe_req && !fifo_grant;
        // A killed head leaves without using the port; a live head only via grant.
        pop        = !reset && head_vld && (head_kill || fifo_grant);
        push       = !reset && llu_valid && !full && (llu_regno != '0);

        llu_ready  = !reset && !full;
        pipe_stall = fifo_grant && pipe_req;
        rf_we      = fifo_grant || pipe_grant;
        rf_wregno  = '0;
        rf_wval    = '0;
        if (fifo_grant) begin
            rf_wregno = mem_regno_q[rd_ptr_q];
            rf_wval   = mem_val_q[rd_ptr_q];
        end else if (pipe_grant) begin
            rf_wregno = pipe_regno;
            rf_wval   = pipe_val;
        end

        mem_regno_d = mem_regno_q;
        mem_val_d   = mem_val_q;
        mem_kill_d  = mem_kill_q;
        // The WB write is program-younger, so it squashes every buffered write to its register.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (pipe_grant && (mem_regno_q[i] == pipe_regno)) mem_kill_d[i] = 1'b1;
        end
        if (push) begin
            mem_regno_d[wr_ptr_q] = llu_regno;
            mem_val_d[wr_ptr_q]   = llu_val;
            mem_kill_d[wr_ptr_q]  = pipe_grant && (llu_regno == pipe_regno);
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        age_d = age_q;
        if (pop) age_d = '0;
        else if (head_live && pipe_grant && (age_q < AGE_LIM)) age_d = age_q + 1'b1;

        stall_cycles_d = stall_cycles_q + 32'(pipe_stall);
        stall_cycles   = stall_cycles_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            age_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            age_q          <= age_d;
            stall_cycles_q <= stall_cycles_d;
        end
        mem_regno_q <= mem_regno_d;
        mem_val_q   <= mem_val_d;
        mem_kill_q  <= mem_kill_d;
    end
endmodule
